// File: rtl/frame_writer.sv
// Ping-pong frame buffer writer: streams RGB pixels into Buf0/Buf1 in raster order,
// alternating buffers per frame and waiting for the target buffer to drain first.
module frame_writer #(
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Run,
    input  logic [CNT_W-1:0]  AIP,
    input  logic [CNT_W-1:0]  AIL,
    input  logic              Buf0Empty,
    input  logic              Buf1Empty,
    input  logic              PixValid,
    input  logic [23:0]       PixData,
    output logic              PixReady,
    output logic [31:0]       WData,
    output logic [ADDR_W-1:0] WAddr,
    output logic              WE0,
    output logic              WE1,
    output logic              ActiveBuf,
    output logic              FrameDone,
    output logic              Busy,
    output logic              CfgErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   aip_q, aip_d;
    logic [CNT_W-1:0]   ail_q, ail_d;
    logic [CNT_W-1:0]   px_q, px_d;
    logic [CNT_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               active_q, active_d;
    logic               cfgerr_q, cfgerr_d;
    logic               we0_q, we0_d;
    logic               we1_q, we1_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic               accept;
    logic               cfg_ok;

    assign PixReady  = (state_q == S_WRITE);
    assign FrameDone = (state_q == S_DONE);
    assign Busy      = (state_q != S_IDLE);
    assign accept    = PixValid & PixReady;
    assign cfg_ok    = (AIP != '0) && (AIL != '0);

    assign WData     = wdata_q;
    assign WAddr     = waddr_q;
    assign WE0       = we0_q;
    assign WE1       = we1_q;
    assign ActiveBuf = active_q;
    assign CfgErr    = cfgerr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            aip_q    <= '0;
            ail_q    <= '0;
            px_q     <= '0;
            line_q   <= '0;
            addr_q   <= '0;
            active_q <= 1'b0;
            cfgerr_q <= 1'b0;
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            wdata_q  <= '0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            aip_q    <= aip_d;
            ail_q    <= ail_d;
            px_q     <= px_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            active_q <= active_d;
            cfgerr_q <= cfgerr_d;
            we0_q    <= we0_d;
            we1_q    <= we1_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        aip_d    = aip_q;
        ail_d    = ail_q;
        px_d     = px_q;
        line_d   = line_q;
        addr_d   = addr_q;
        active_d = active_q;
        cfgerr_d = cfgerr_q;

        // Write port is a one-cycle registered copy of the accepted pixel.
        we0_d   = accept & ~active_q;
        we1_d   = accept & active_q;
        wdata_d = accept ? {8'h00, PixData} : wdata_q;
        waddr_d = accept ? addr_q : waddr_q;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    if (cfg_ok) begin
                        aip_d   = AIP;
                        ail_d   = AIL;
                        px_d    = '0;
                        line_d  = '0;
                        addr_d  = '0;
                        state_d = S_WAIT_BUF;
                    end else begin
                        cfgerr_d = 1'b1;
                    end
                end
            end
            S_WAIT_BUF: begin
                if (active_q ? Buf1Empty : Buf0Empty) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Empty is not re-examined here: a started frame always completes.
                if (accept) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (px_q == aip_q - CNT_ONE) begin
                        px_d = '0;
                        if (line_q == ail_q - CNT_ONE) begin
                            state_d = S_DONE;
                        end else begin
                            line_d = line_q + CNT_ONE;
                        end
                    end else begin
                        px_d = px_q + CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                px_d     = '0;
                line_d   = '0;
                addr_d   = '0;
                active_d = ~active_q;
                state_d  = S_IDLE;
                if (Run) begin
                    if (cfg_ok) begin
                        aip_d   = AIP;
                        ail_d   = AIL;
                        state_d = S_WAIT_BUF;
                    end else begin
                        cfgerr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: reset, frame writes, buffer stall, gaps, config error, mid-frame reset.
module tb_frame_writer;

    logic        clk;
    logic        reset;
    logic        Run;
    logic [9:0]  AIP;
    logic [9:0]  AIL;
    logic        Buf0Empty;
    logic        Buf1Empty;
    logic        PixValid;
    logic [23:0] PixData;
    logic        PixReady;
    logic [31:0] WData;
    logic [19:0] WAddr;
    logic        WE0;
    logic        WE1;
    logic        ActiveBuf;
    logic        FrameDone;
    logic        Busy;
    logic        CfgErr;

    int n_cmp = 0;
    int n_err = 0;

    frame_writer #(.ADDR_W(20), .CNT_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .Run       (Run),
        .AIP       (AIP),
        .AIL       (AIL),
        .Buf0Empty (Buf0Empty),
        .Buf1Empty (Buf1Empty),
        .PixValid  (PixValid),
        .PixData   (PixData),
        .PixReady  (PixReady),
        .WData     (WData),
        .WAddr     (WAddr),
        .WE0       (WE0),
        .WE1       (WE1),
        .ActiveBuf (ActiveBuf),
        .FrameDone (FrameDone),
        .Busy      (Busy),
        .CfgErr    (CfgErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},  32'(Busy),      32'd0);
        chk({tag, ".ready"}, 32'(PixReady),  32'd0);
        chk({tag, ".we0"},   32'(WE0),       32'd0);
        chk({tag, ".we1"},   32'(WE1),       32'd0);
        chk({tag, ".done"},  32'(FrameDone), 32'd0);
    endtask

    task automatic chk_write(input string tag, input logic buf_sel, input int addr, input logic [23:0] data,
                             input logic done);
        chk({tag, ".we0"},   32'(WE0),       32'(!buf_sel));
        chk({tag, ".we1"},   32'(WE1),       32'(buf_sel));
        chk({tag, ".waddr"}, 32'(WAddr),     32'(addr));
        chk({tag, ".wdata"}, WData,          {8'h00, data});
        chk({tag, ".done"},  32'(FrameDone), 32'(done));
    endtask

    logic [9:0] pat;
    int acc;

    initial begin
        reset = 1'b0; Run = 1'b0; AIP = 10'd4; AIL = 10'd2;
        Buf0Empty = 1'b0; Buf1Empty = 1'b0; PixValid = 1'b0; PixData = 24'h0;

        // T1: async reset takes effect before any clock edge
        #2 reset = 1'b1;
        #1;
        chk_idle_outputs("t1");
        chk("t1.waddr",  32'(WAddr),     32'd0);
        chk("t1.wdata",  WData,          32'd0);
        chk("t1.active", 32'(ActiveBuf), 32'd0);
        chk("t1.cfgerr", 32'(CfgErr),    32'd0);
        tick; tick;
        reset = 1'b0;
        tick;

        // T2: 4x2 frame into Buf0
        Run = 1'b1; Buf0Empty = 1'b1; PixValid = 1'b1; PixData = 24'h000001;
        tick;
        chk("t2.wait_busy",  32'(Busy),     32'd1);
        chk("t2.wait_ready", 32'(PixReady), 32'd0);
        tick;
        chk("t2.write_ready", 32'(PixReady), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            PixData = 24'(i);
            tick;
            chk_write($sformatf("t2.px%0d", i), 1'b0, i - 1, 24'(i), i == 8);
        end
        chk("t2.done_active", 32'(ActiveBuf), 32'd0);
        PixValid = 1'b0;
        tick;
        chk("t2.post_active", 32'(ActiveBuf), 32'd1);
        chk("t2.post_we0",    32'(WE0),       32'd0);
        chk("t2.post_done",   32'(FrameDone), 32'd0);
        chk("t2.post_busy",   32'(Busy),      32'd1);

        // T3: Buf1 not drained -> stall with no writes, address held
        PixValid = 1'b1; PixData = 24'h0000FF;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("t3.stall%0d.ready", i), 32'(PixReady), 32'd0);
            chk($sformatf("t3.stall%0d.we0", i),   32'(WE0),      32'd0);
            chk($sformatf("t3.stall%0d.we1", i),   32'(WE1),      32'd0);
            chk($sformatf("t3.stall%0d.waddr", i), 32'(WAddr),    32'd7);
        end
        Buf1Empty = 1'b1;
        tick;
        chk("t3.go_ready", 32'(PixReady), 32'd1);

        // T4: valid gaps on the Buf1 frame; addresses stay contiguous
        pat = 10'b1111101101;   // applied LSB first: 1,0,1,1,0,1,1,1,1,1
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            PixValid = pat[k];
            PixData  = 24'h000100 + 24'(acc);
            tick;
            if (pat[k]) begin
                chk_write($sformatf("t4.s%0d", k), 1'b1, acc, 24'h000100 + 24'(acc), acc == 7);
                acc++;
            end else begin
                chk($sformatf("t4.s%0d.we1", k),   32'(WE1),   32'd0);
                chk($sformatf("t4.s%0d.we0", k),   32'(WE0),   32'd0);
                chk($sformatf("t4.s%0d.waddr", k), 32'(WAddr), 32'(acc - 1));
            end
        end
        PixValid = 1'b0; Run = 1'b0;
        tick;
        chk("t4.idle_busy",   32'(Busy),      32'd0);
        chk("t4.idle_active", 32'(ActiveBuf), 32'd0);

        // T5: zero AIP -> sticky CfgErr
        AIP = 10'd0; AIL = 10'd2; Run = 1'b1;
        tick;
        chk("t5.cfgerr", 32'(CfgErr), 32'd1);
        chk_idle_outputs("t5.a");
        tick;
        chk_idle_outputs("t5.b");
        Run = 1'b0; AIP = 10'd2; AIL = 10'd1;
        tick;
        chk("t5.sticky", 32'(CfgErr), 32'd1);

        // 2x1 frame on Buf0; size changes mid-frame must not shorten or extend it
        Run = 1'b1;
        tick;
        tick;
        chk("t5.f_ready", 32'(PixReady), 32'd1);
        PixValid = 1'b1; PixData = 24'h000200; AIP = 10'd7;
        tick;
        chk_write("t5.f0", 1'b0, 0, 24'h000200, 1'b0);
        PixData = 24'h000201; AIP = 10'd4; AIL = 10'd2;
        tick;
        chk_write("t5.f1", 1'b0, 1, 24'h000201, 1'b1);
        chk("t5.sticky2", 32'(CfgErr), 32'd1);
        tick;
        chk("t5.next_active", 32'(ActiveBuf), 32'd1);
        chk("t5.next_we0",    32'(WE0),       32'd0);
        tick;
        chk("t6.b1_ready", 32'(PixReady), 32'd1);

        // T6: reset after 3 accepts of the Buf1 frame
        for (int i = 0; i < 3; i++) begin
            PixData = 24'h000300 + 24'(i);
            tick;
            chk_write($sformatf("t6.b1px%0d", i), 1'b1, i, 24'h000300 + 24'(i), 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        chk_idle_outputs("t6.rst");
        chk("t6.rst_waddr",  32'(WAddr),     32'd0);
        chk("t6.rst_wdata",  WData,          32'd0);
        chk("t6.rst_active", 32'(ActiveBuf), 32'd0);
        chk("t6.rst_cfgerr", 32'(CfgErr),    32'd0);
        #1 reset = 1'b0;
        AIP = 10'd2; AIL = 10'd1; Run = 1'b1; Buf0Empty = 1'b1; PixData = 24'h000400;
        tick;
        tick;
        chk("t6.re_ready", 32'(PixReady), 32'd1);
        tick;
        chk_write("t6.re0", 1'b0, 0, 24'h000400, 1'b0);
        PixData = 24'h000401; Run = 1'b0;
        tick;
        chk_write("t6.re1", 1'b0, 1, 24'h000401, 1'b1);
        PixValid = 1'b0;
        tick;
        chk("t6.end_busy",   32'(Busy),      32'd0);
        chk("t6.end_active", 32'(ActiveBuf), 32'd1);
        chk("t6.end_we0",    32'(WE0),       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
